rat_recovery_ctrl: RTL and testbench
====================================

RAT_RECOVERY_CTRL -- requirements
Module: rat_recovery_ctrl

Interface
REQ-001 The block SHALL have parameter ARCH_REGS, default 32, giving the number of architectural registers.
REQ-002 The block SHALL have parameter PHY_WIDTH, default 6, giving the physical-register tag width.
REQ-003 The block SHALL have parameter LANES, default 4, giving the front-RAT entries written per cycle; ARCH_REGS SHALL be a multiple of LANES.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-006 recover_req  input  1  recovery request from the ROB on mispredict or exception; level-sampled.
REQ-007 retire_valid  input  1  commit of a rename mapping into the committed map in this cycle.
REQ-008 back_rat  input  PHY_WIDTH*ARCH_REGS  packed committed map; entry i occupies bits [(i+1)*PHY_WIDTH-1 : i*PHY_WIDTH].
REQ-009 back_rat_freeze  output  1  blocks committed-map updates; drives the committed map's stall.
REQ-010 rename_stall  output  1  holds rename and front-RAT lookups.
REQ-011 rat_wr_en  output  LANES  per-lane front-RAT write enable.
REQ-012 rat_wr_arch  output  5*LANES  per-lane architectural index.
REQ-013 rat_wr_phy  output  PHY_WIDTH*LANES  per-lane physical tag.
REQ-014 recover_done  output  1  one-cycle pulse at the end of each completed pass.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, DRAIN, SNAP, COPY and DONE.
REQ-017 IDLE with recover_req=1 SHALL go to DRAIN; otherwise IDLE SHALL stay in IDLE.
REQ-018 DRAIN SHALL stay in DRAIN while retire_valid=1 and SHALL go to SNAP in the first cycle retire_valid=0; there is no timeout.
REQ-019 SNAP SHALL capture all of back_rat into an internal snapshot register at its exiting edge and SHALL go to COPY.
REQ-020 COPY SHALL last exactly ARCH_REGS/LANES cycles, driven by a group counter that starts at 0 and increments by 1 per cycle.
REQ-021 In COPY with counter value g, lane k SHALL drive rat_wr_en[k]=1, rat_wr_arch=g*LANES+k and rat_wr_phy=snapshot[g*LANES+k].
REQ-022 Architectural index 0 SHALL be written like any other entry, with no masking.
REQ-023 The last COPY cycle (g=ARCH_REGS/LANES-1) SHALL go to DONE; the counter SHALL return to 0 and SHALL NOT wrap mid-pass.
REQ-024 DONE SHALL assert recover_done for exactly one cycle, then go to DRAIN if the pending flag is set, else to IDLE.
REQ-025 rat_wr_en SHALL be all-zero outside COPY; rat_wr_arch and rat_wr_phy SHALL be 0 outside COPY.
REQ-026 back_rat_freeze SHALL be 1 in SNAP and COPY, so the snapshot cannot diverge from the committed map before the front RAT matches it.
REQ-027 back_rat_freeze SHALL be 0 in IDLE, DRAIN and DONE.
REQ-028 rename_stall SHALL be 1 in DRAIN, SNAP, COPY and DONE, and 0 only in IDLE.
REQ-029 recover_req=1 while the FSM is in any state other than IDLE SHALL set a pending flag; the flag SHALL be cleared on the DONE->DRAIN transition.
REQ-030 Repeated requests during one pass SHALL collapse into a single extra pass.
REQ-031 recover_req=1 in DONE SHALL set the pending flag, and the FSM SHALL go to DRAIN.
REQ-032 Latency with retire_valid=0 SHALL be: request sampled at edge E0; DRAIN at E0+1; SNAP at E0+2; COPY from E0+3 to E0+2+ARCH_REGS/LANES; recover_done in the following cycle (E0+11 with defaults).
REQ-033 All outputs SHALL be registered or decoded from registered state only, with no combinational path from an input to an output.

Reset
REQ-034 rst_n=0 SHALL immediately force the FSM to IDLE and clear the group counter, the pending flag and the snapshot.
REQ-035 While rst_n=0, every output SHALL be 0: busy=0, rename_stall=0, back_rat_freeze=0, rat_wr_en=0, recover_done=0.
REQ-036 Reset asserted mid-COPY SHALL abort the pass with no further writes and no recover_done pulse.
REQ-037 The first request after rst_n rises SHALL start a full pass from group 0.

Verification
REQ-038 Default parameters, back_rat entry i = i+32, one-cycle recover_req, retire_valid=0 -> 8 COPY cycles writing arch 0..31 with phy 32..63 in groups {0-3},{4-7},...; recover_done exactly 11 cycles after request; rename_stall high throughout.
REQ-039 retire_valid held 1 for 5 cycles after the request -> FSM stays in DRAIN 5 extra cycles; snapshot taken after the last retire; back_rat_freeze low during DRAIN.
REQ-040 Change back_rat entry 7 from 39 to 50 during COPY group 0 -> group 1 still writes arch 7 with 39, because the snapshot holds.
REQ-041 recover_req pulsed twice during COPY -> one recover_done, then exactly one more full pass, then IDLE; two recover_done pulses total.
REQ-042 rst_n driven low at COPY group 3 -> outputs zero in the same cycle; no recover_done; the next request yields a complete 8-group pass.
REQ-043 LANES=8, ARCH_REGS=32 -> 4 COPY cycles; recover_done 7 cycles after the request with retire_valid=0.

Source files
------------

// File: rtl/rat_recovery_ctrl.sv
// Front-RAT recovery sequencer: drains retirement, snapshots the committed map,
// then replays it into the front RAT LANES entries per cycle.
`timescale 1ns/1ps

// state | meaning
// IDLE  | no recovery in progress, rename free-running
// DRAIN | waiting for retirement to go quiet before snapshotting
// SNAP  | committed map frozen, captured at the exiting edge
// COPY  | replaying the snapshot into the front RAT, one lane group per cycle
// DONE  | one-cycle completion pulse, restart if another request arrived
module rat_recovery_ctrl #(
  parameter int ARCH_REGS = 32,
  parameter int PHY_WIDTH = 6,
  parameter int LANES     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           recover_req,
  input  logic                           retire_valid,
  input  logic [PHY_WIDTH*ARCH_REGS-1:0] back_rat,
  output logic                           back_rat_freeze,
  output logic                           rename_stall,
  output logic [LANES-1:0]               rat_wr_en,
  output logic [5*LANES-1:0]             rat_wr_arch,
  output logic [PHY_WIDTH*LANES-1:0]     rat_wr_phy,
  output logic                           recover_done,
  output logic                           busy
);

  localparam int GROUPS = ARCH_REGS / LANES;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [GW-1:0] LAST_GRP = GW'(GROUPS - 1);

  typedef enum logic [2:0] {IDLE, DRAIN, SNAP, COPY, DONE} state_e;

  state_e                         state_q;
  logic [GW-1:0]                  grp_q;
  logic                           pending_q;
  logic [PHY_WIDTH*ARCH_REGS-1:0] snap_q;

  // A request seen in DONE is consumed by the restart itself, so the pending
  // clear on DONE->DRAIN deliberately overrides the set issued in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grp_q     <= '0;
      pending_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      if (recover_req && (state_q != IDLE)) pending_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (recover_req) state_q <= DRAIN;
        end
        DRAIN: begin
          if (!retire_valid) state_q <= SNAP;
        end
        SNAP: begin
          snap_q  <= back_rat;
          grp_q   <= '0;
          state_q <= COPY;
        end
        COPY: begin
          if (grp_q == LAST_GRP) begin
            grp_q   <= '0;
            state_q <= DONE;
          end else begin
            grp_q <= grp_q + GW'(1);
          end
        end
        DONE: begin
          if (pending_q || recover_req) begin
            pending_q <= 1'b0;
            state_q   <= DRAIN;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    busy            = (state_q != IDLE);
    rename_stall    = (state_q != IDLE);
    back_rat_freeze = (state_q == SNAP) || (state_q == COPY);
    recover_done    = (state_q == DONE);
    rat_wr_en       = '0;
    rat_wr_arch     = '0;
    rat_wr_phy      = '0;
    if (state_q == COPY) begin
      for (int k = 0; k < LANES; k++) begin
        rat_wr_en[k]                       = 1'b1;
        rat_wr_arch[k*5 +: 5]              = 5'(int'(grp_q) * LANES + k);
        rat_wr_phy[k*PHY_WIDTH +: PHY_WIDTH] =
          snap_q[(int'(grp_q) * LANES + k) * PHY_WIDTH +: PHY_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_rat_recovery_ctrl.sv
// Directed bench for rat_recovery_ctrl: default 4-lane instance plus an
// 8-lane instance sharing clock, reset and committed map.
`timescale 1ns/1ps

module tb_rat_recovery_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req = 1'b0;
  logic         retire = 1'b0;
  logic         req8 = 1'b0;
  logic         retire8 = 1'b0;
  logic [191:0] back_rat;

  logic         freeze, stall, done, busy;
  logic [3:0]   en;
  logic [19:0]  arch;
  logic [23:0]  phy;

  logic         freeze8, stall8, done8, busy8;
  logic [7:0]   en8;
  logic [39:0]  arch8;
  logic [47:0]  phy8;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  rat_recovery_ctrl #(.ARCH_REGS(32), .PHY_WIDTH(6), .LANES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .recover_req(req), .retire_valid(retire),
    .back_rat(back_rat), .back_rat_freeze(freeze), .rename_stall(stall),
    .rat_wr_en(en), .rat_wr_arch(arch), .rat_wr_phy(phy),
    .recover_done(done), .busy(busy)
  );

  rat_recovery_ctrl #(.ARCH_REGS(32), .PHY_WIDTH(6), .LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .recover_req(req8), .retire_valid(retire8),
    .back_rat(back_rat), .back_rat_freeze(freeze8), .rename_stall(stall8),
    .rat_wr_en(en8), .rat_wr_arch(arch8), .rat_wr_phy(phy8),
    .recover_done(done8), .busy(busy8)
  );

  task automatic load_default_rat();
    for (int i = 0; i < 32; i++) back_rat[i*6 +: 6] = 6'(i + 32);
  endtask

  task automatic test_reset();
    load_default_rat();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, stall, freeze, done, en, arch, phy} !== 52'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b stall=%b freeze=%b done=%b en=%h arch=%h phy=%h, expected all 0",
               busy, stall, freeze, done, en, arch, phy);
    end
    vectors++;
    if ({busy8, stall8, freeze8, done8, en8, arch8, phy8} !== 100'd0) begin
      errors++;
      $display("FAIL reset_outputs8: got busy=%b stall=%b en=%h, expected all 0", busy8, stall8, en8);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b stall=%b, expected 0 0", busy, stall);
    end
  endtask

  task automatic test_basic_pass();
    logic [19:0] exp_arch;
    logic [23:0] exp_phy;
    int done_cnt = 0;
    req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) req = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (n <= 11) begin
        vectors++;
        if (stall !== 1'b1) begin
          errors++;
          $display("FAIL basic_stall n=%0d: got %b expected 1", n, stall);
        end
      end
      if (n == 1 || n == 11) begin
        vectors++;
        if (freeze !== 1'b0 || en !== 4'h0) begin
          errors++;
          $display("FAIL basic_idle_outputs n=%0d: got freeze=%b en=%h expected 0 0", n, freeze, en);
        end
      end
      if (n >= 3 && n <= 10) begin
        for (int k = 0; k < 4; k++) begin
          exp_arch[k*5 +: 5] = 5'((n - 3) * 4 + k);
          exp_phy[k*6 +: 6]  = 6'((n - 3) * 4 + k + 32);
        end
        vectors++;
        if (en !== 4'hF || freeze !== 1'b1 || arch !== exp_arch || phy !== exp_phy) begin
          errors++;
          $display("FAIL basic_copy g=%0d: got en=%h freeze=%b arch=%h phy=%h expected en=f freeze=1 arch=%h phy=%h",
                   n - 3, en, freeze, arch, phy, exp_arch, exp_phy);
        end
      end
      if (n == 11) begin
        vectors++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL basic_done_latency: got done=%b at cycle 11 expected 1", done);
        end
      end
      if (n == 12) begin
        vectors++;
        if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL basic_return_idle: got busy=%b stall=%b done=%b expected 0 0 0", busy, stall, done);
        end
      end
    end
    vectors++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL basic_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_drain();
    req = 1'b1;
    for (int n = 1; n <= 17; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin
        req = 1'b0;
        retire = 1'b1;
        back_rat[3*6 +: 6] = 6'd60;
      end
      if (n == 6) retire = 1'b0;
      if (n <= 6) begin
        vectors++;
        if (freeze !== 1'b0 || busy !== 1'b1 || en !== 4'h0) begin
          errors++;
          $display("FAIL drain_hold n=%0d: got freeze=%b busy=%b en=%h expected 0 1 0", n, freeze, busy, en);
        end
      end
      if (n == 7) begin
        vectors++;
        if (freeze !== 1'b1 || en !== 4'h0) begin
          errors++;
          $display("FAIL drain_snap: got freeze=%b en=%h expected 1 0", freeze, en);
        end
      end
      if (n == 8) begin
        vectors++;
        if (en !== 4'hF || phy !== {6'd60, 6'd34, 6'd33, 6'd32}) begin
          errors++;
          $display("FAIL drain_snapshot_g0: got en=%h phy=%h expected f %h", en, phy, {6'd60, 6'd34, 6'd33, 6'd32});
        end
      end
      if (n == 15 || n == 16) begin
        vectors++;
        if (done !== (n == 16)) begin
          errors++;
          $display("FAIL drain_done n=%0d: got %b expected %b", n, done, (n == 16));
        end
      end
      if (n == 17) begin
        vectors++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL drain_idle: got busy=%b expected 0", busy);
        end
      end
    end
    load_default_rat();
  endtask

  task automatic test_snapshot_hold();
    req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) req = 1'b0;
      if (n == 3) begin
        vectors++;
        if (arch !== {5'd3, 5'd2, 5'd1, 5'd0}) begin
          errors++;
          $display("FAIL hold_g0_arch: got %h expected %h", arch, {5'd3, 5'd2, 5'd1, 5'd0});
        end
        back_rat[7*6 +: 6] = 6'd50;
      end
      if (n == 4) begin
        vectors++;
        if (arch[15 +: 5] !== 5'd7 || phy[18 +: 6] !== 6'd39) begin
          errors++;
          $display("FAIL hold_arch7: got arch=%0d phy=%0d expected 7 39", arch[15 +: 5], phy[18 +: 6]);
        end
        vectors++;
        if (phy !== {6'd39, 6'd38, 6'd37, 6'd36}) begin
          errors++;
          $display("FAIL hold_g1_phy: got %h expected %h", phy, {6'd39, 6'd38, 6'd37, 6'd36});
        end
      end
    end
    load_default_rat();
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    int copy_cnt = 0;
    req = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk); #1;
      if (n == 1 || n == 5 || n == 7) req = 1'b0;
      if (n == 4 || n == 6) req = 1'b1;
      if (done === 1'b1) done_cnt++;
      if (en === 4'hF) copy_cnt++;
      if (n == 11 || n == 22) begin
        vectors++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done n=%0d: got %b expected 1", n, done);
        end
      end
      if (n == 12) begin
        vectors++;
        if (busy !== 1'b1 || freeze !== 1'b0 || en !== 4'h0 || done !== 1'b0) begin
          errors++;
          $display("FAIL b2b_restart_drain: got busy=%b freeze=%b en=%h done=%b expected 1 0 0 0", busy, freeze, en, done);
        end
      end
      if (n == 14) begin
        vectors++;
        if (en !== 4'hF || arch !== {5'd3, 5'd2, 5'd1, 5'd0} || phy !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
          errors++;
          $display("FAIL b2b_second_g0: got en=%h arch=%h phy=%h", en, arch, phy);
        end
      end
      if (n == 23) begin
        vectors++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_final_idle: got busy=%b expected 0", busy);
        end
      end
    end
    vectors++;
    if (done_cnt !== 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", done_cnt);
    end
    vectors++;
    if (copy_cnt !== 16) begin
      errors++;
      $display("FAIL b2b_copy_cycles: got %0d expected 16", copy_cnt);
    end
  endtask

  task automatic test_reset_mid_copy();
    int done_cnt = 0;
    int copy_cnt = 0;
    req = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      if (n == 1) req = 1'b0;
    end
    vectors++;
    if (en !== 4'hF || arch !== {5'd15, 5'd14, 5'd13, 5'd12}) begin
      errors++;
      $display("FAIL abort_at_g3: got en=%h arch=%h expected f %h", en, arch, {5'd15, 5'd14, 5'd13, 5'd12});
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, stall, freeze, done, en, arch, phy} !== 52'd0) begin
      errors++;
      $display("FAIL abort_outputs_zero: got busy=%b stall=%b freeze=%b done=%b en=%h arch=%h phy=%h expected all 0",
               busy, stall, freeze, done, en, arch, phy);
    end
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || en !== 4'h0) begin
        errors++;
        $display("FAIL abort_in_reset: got done=%b en=%h expected 0 0", done, en);
      end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_resume: got busy=%b done=%b expected 0 0", busy, done);
    end
    req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 1) req = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (en === 4'hF) copy_cnt++;
      if (n == 3) begin
        vectors++;
        if (arch !== {5'd3, 5'd2, 5'd1, 5'd0} || phy !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
          errors++;
          $display("FAIL abort_restart_g0: got arch=%h phy=%h", arch, phy);
        end
      end
      if (n == 11) begin
        vectors++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL abort_restart_done: got %b expected 1", done);
        end
      end
    end
    vectors++;
    if (copy_cnt !== 8 || done_cnt !== 1) begin
      errors++;
      $display("FAIL abort_restart_full: got copy=%0d done=%0d expected 8 1", copy_cnt, done_cnt);
    end
  endtask

  task automatic test_lanes8();
    logic [39:0] exp_arch;
    logic [47:0] exp_phy;
    int done_cnt = 0;
    int copy_cnt = 0;
    req8 = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      @(posedge clk); #1;
      if (n == 1) req8 = 1'b0;
      if (done8 === 1'b1) done_cnt++;
      if (en8 === 8'hFF) copy_cnt++;
      if (n >= 3 && n <= 6) begin
        for (int k = 0; k < 8; k++) begin
          exp_arch[k*5 +: 5] = 5'((n - 3) * 8 + k);
          exp_phy[k*6 +: 6]  = 6'((n - 3) * 8 + k + 32);
        end
        vectors++;
        if (en8 !== 8'hFF || arch8 !== exp_arch || phy8 !== exp_phy || stall8 !== 1'b1) begin
          errors++;
          $display("FAIL lanes8_copy g=%0d: got en=%h arch=%h phy=%h expected ff %h %h",
                   n - 3, en8, arch8, phy8, exp_arch, exp_phy);
        end
      end
      if (n == 7) begin
        vectors++;
        if (done8 !== 1'b1) begin
          errors++;
          $display("FAIL lanes8_done_latency: got %b at cycle 7 expected 1", done8);
        end
      end
      if (n == 8) begin
        vectors++;
        if (busy8 !== 1'b0) begin
          errors++;
          $display("FAIL lanes8_idle: got busy=%b expected 0", busy8);
        end
      end
    end
    vectors++;
    if (copy_cnt !== 4 || done_cnt !== 1) begin
      errors++;
      $display("FAIL lanes8_counts: got copy=%0d done=%0d expected 4 1", copy_cnt, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic_pass();
    test_drain();
    test_snapshot_hold();
    test_back_to_back();
    test_reset_mid_copy();
    test_lanes8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
